// File: rtl/watch_set_ctrl.sv
// Watch set-mode controller: run/set FSM with a sec/min/hour cursor, single-cycle
// up/down pulses with hold-to-auto-repeat, and the set-mode blink for the display.
module watch_set_ctrl #(
   parameter int unsigned HOLD_CYCLES   = 50_000_000,
   parameter int unsigned REPEAT_CYCLES = 10_000_000,
   parameter int unsigned BLINK_CYCLES  = 25_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       i_btn_mode,
   input  logic       i_btn_left,
   input  logic       i_btn_right,
   input  logic       i_btn_up,
   input  logic       i_btn_down,
   output logic       o_sec_up,
   output logic       o_sec_down,
   output logic       o_min_up,
   output logic       o_min_down,
   output logic       o_hour_up,
   output logic       o_hour_down,
   output logic       o_set_mode,
   output logic [1:0] o_field,
   output logic       o_blink
);

   localparam int unsigned HW      = $clog2(HOLD_CYCLES);
   localparam int unsigned RW      = $clog2(REPEAT_CYCLES);
   localparam int unsigned BW      = $clog2(BLINK_CYCLES);
   localparam int unsigned NB      = 5;
   localparam int unsigned B_MODE  = 0;
   localparam int unsigned B_LEFT  = 1;
   localparam int unsigned B_RIGHT = 2;
   localparam int unsigned B_UP    = 3;
   localparam int unsigned B_DOWN  = 4;

   localparam logic [HW-1:0] HOLD_LAST   = HW'(HOLD_CYCLES - 1);
   localparam logic [RW-1:0] REPEAT_LAST = RW'(REPEAT_CYCLES - 1);
   localparam logic [BW-1:0] BLINK_LAST  = BW'(BLINK_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_RUN  = 2'd0,
      ST_SEC  = 2'd1,
      ST_MIN  = 2'd2,
      ST_HOUR = 2'd3
   } state_e;

   state_e          state_q, state_d;
   logic [NB-1:0]   btn_c, edge_c, btn_prev_q;
   logic            smp_vld_q;
   logic            armed_q, armed_d;
   logic            dir_q, dir_d;
   logic            rep_ph_q, rep_ph_d;
   logic [HW-1:0]   hold_cnt_q, hold_cnt_d;
   logic [RW-1:0]   rep_cnt_q, rep_cnt_d;
   logic            blink_q, blink_d;
   logic [BW-1:0]   blink_cnt_q, blink_cnt_d;
   logic [5:0]      pulse_q, pulse_d;
   logic            fire_c, field_chg_c;
   logic [1:0]      dir_oh_c;

   // The first sample after reset only primes the edge register
   assign btn_c  = {i_btn_down, i_btn_up, i_btn_right, i_btn_left, i_btn_mode};
   assign edge_c = btn_c & ~btn_prev_q & {NB{smp_vld_q}};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= ST_RUN;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (edge_c[B_MODE]) begin
         state_d = (state_q == ST_RUN) ? ST_SEC : ST_RUN;
      end else if (state_q != ST_RUN && (edge_c[B_LEFT] != edge_c[B_RIGHT])) begin
         case (state_q)
            ST_SEC:  state_d = edge_c[B_LEFT] ? ST_MIN  : ST_HOUR;
            ST_MIN:  state_d = edge_c[B_LEFT] ? ST_HOUR : ST_SEC;
            ST_HOUR: state_d = edge_c[B_LEFT] ? ST_SEC  : ST_MIN;
            default: state_d = ST_RUN;
         endcase
      end
   end

   always_comb begin
      armed_d     = armed_q;
      dir_d       = dir_q;
      rep_ph_d    = rep_ph_q;
      hold_cnt_d  = hold_cnt_q;
      rep_cnt_d   = rep_cnt_q;
      blink_d     = blink_q;
      blink_cnt_d = blink_cnt_q;
      pulse_d     = '0;
      fire_c      = 1'b0;
      dir_oh_c    = 2'b00;
      field_chg_c = (state_d != state_q);

      // Any disturbance drops the repeat; only a fresh press re-arms it
      if (state_d == ST_RUN || field_chg_c || (btn_c[B_UP] && btn_c[B_DOWN])) begin
         armed_d    = 1'b0;
         rep_ph_d   = 1'b0;
         hold_cnt_d = '0;
         rep_cnt_d  = '0;
      end else if (edge_c[B_UP] || edge_c[B_DOWN]) begin
         fire_c     = 1'b1;
         armed_d    = 1'b1;
         dir_d      = edge_c[B_DOWN];
         rep_ph_d   = 1'b0;
         hold_cnt_d = '0;
         rep_cnt_d  = '0;
      end else if (armed_q && (dir_q ? btn_c[B_DOWN] : btn_c[B_UP])) begin
         if (!rep_ph_q) begin
            if (hold_cnt_q == HOLD_LAST) begin
               fire_c     = 1'b1;
               rep_ph_d   = 1'b1;
               hold_cnt_d = '0;
               rep_cnt_d  = '0;
            end else begin
               hold_cnt_d = hold_cnt_q + HW'(1);
            end
         end else if (rep_cnt_q == REPEAT_LAST) begin
            fire_c    = 1'b1;
            rep_cnt_d = '0;
         end else begin
            rep_cnt_d = rep_cnt_q + RW'(1);
         end
      end else begin
         armed_d    = 1'b0;
         rep_ph_d   = 1'b0;
         hold_cnt_d = '0;
         rep_cnt_d  = '0;
      end

      dir_oh_c = dir_d ? 2'b10 : 2'b01;
      if (fire_c) begin
         case (state_q)
            ST_SEC:  pulse_d[1:0] = dir_oh_c;
            ST_MIN:  pulse_d[3:2] = dir_oh_c;
            ST_HOUR: pulse_d[5:4] = dir_oh_c;
            default: pulse_d      = '0;
         endcase
      end

      if (state_d == ST_RUN) begin
         blink_d     = 1'b0;
         blink_cnt_d = '0;
      end else if (field_chg_c) begin
         blink_d     = 1'b1;
         blink_cnt_d = '0;
      end else if (blink_cnt_q == BLINK_LAST) begin
         blink_d     = ~blink_q;
         blink_cnt_d = '0;
      end else begin
         blink_cnt_d = blink_cnt_q + BW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         btn_prev_q  <= '0;
         smp_vld_q   <= 1'b0;
         armed_q     <= 1'b0;
         dir_q       <= 1'b0;
         rep_ph_q    <= 1'b0;
         hold_cnt_q  <= '0;
         rep_cnt_q   <= '0;
         blink_q     <= 1'b0;
         blink_cnt_q <= '0;
         pulse_q     <= '0;
      end else begin
         btn_prev_q  <= btn_c;
         smp_vld_q   <= 1'b1;
         armed_q     <= armed_d;
         dir_q       <= dir_d;
         rep_ph_q    <= rep_ph_d;
         hold_cnt_q  <= hold_cnt_d;
         rep_cnt_q   <= rep_cnt_d;
         blink_q     <= blink_d;
         blink_cnt_q <= blink_cnt_d;
         pulse_q     <= pulse_d;
      end
   end

   assign o_sec_up    = pulse_q[0];
   assign o_sec_down  = pulse_q[1];
   assign o_min_up    = pulse_q[2];
   assign o_min_down  = pulse_q[3];
   assign o_hour_up   = pulse_q[4];
   assign o_hour_down = pulse_q[5];
   assign o_set_mode  = (state_q != ST_RUN);
   assign o_field     = state_q;
   assign o_blink     = blink_q;

endmodule

// File: tb/tb_watch_set_ctrl.sv
// Bench for watch_set_ctrl: vector table, directed multi-cycle sequences and
// random button activity, all compared cycle by cycle against a timestamp model.
module tb_watch_set_ctrl;

   localparam int unsigned H = 10;
   localparam int unsigned R = 4;
   localparam int unsigned B = 8;

   // btn bit order: {down, up, right, left, mode}
   // pulse bit order: {hour_down, hour_up, min_down, min_up, sec_down, sec_up}
   typedef struct {
      logic [4:0] btn;
      logic [1:0] field;
      logic       set_mode;
      logic [5:0] pulse;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] btn;
   logic       o_sec_up, o_sec_down, o_min_up, o_min_down, o_hour_up, o_hour_down;
   logic       o_set_mode, o_blink;
   logic [1:0] o_field;
   logic [5:0] pulses;

   int checks = 0;
   int errors = 0;

   int         cyc;
   int         m_field;
   logic [4:0] m_prev;
   logic       m_vld;
   logic       m_armed;
   logic       m_dir;
   int         m_press;
   int         m_t0;
   logic [5:0] m_pulse;
   logic       m_blink;

   always #5 clk = ~clk;

   assign pulses = {o_hour_down, o_hour_up, o_min_down, o_min_up, o_sec_down, o_sec_up};

   watch_set_ctrl #(
      .HOLD_CYCLES  (H),
      .REPEAT_CYCLES(R),
      .BLINK_CYCLES (B)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .i_btn_mode (btn[0]),
      .i_btn_left (btn[1]),
      .i_btn_right(btn[2]),
      .i_btn_up   (btn[3]),
      .i_btn_down (btn[4]),
      .o_sec_up   (o_sec_up),
      .o_sec_down (o_sec_down),
      .o_min_up   (o_min_up),
      .o_min_down (o_min_down),
      .o_hour_up  (o_hour_up),
      .o_hour_down(o_hour_down),
      .o_set_mode (o_set_mode),
      .o_field    (o_field),
      .o_blink    (o_blink)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_field = 0;
      m_prev  = '0;
      m_vld   = 1'b0;
      m_armed = 1'b0;
      m_dir   = 1'b0;
      m_press = 0;
      m_t0    = 0;
      m_pulse = '0;
      m_blink = 1'b0;
   endtask

   // Pulses are computed from the press timestamp: k+1, then k+1+H+n*R while held.
   task automatic model_step();
      logic [4:0] e;
      int         nf;
      int         d;
      logic       fire;
      cyc++;
      e      = btn & ~m_prev & {5{m_vld}};
      m_prev = btn;
      m_vld  = 1'b1;
      nf     = m_field;
      if (e[0]) nf = (m_field == 0) ? 1 : 0;
      else if (m_field != 0 && e[1] != e[2]) nf = ((m_field - 1 + (e[1] ? 1 : 2)) % 3) + 1;
      fire = 1'b0;
      if (nf == 0 || nf != m_field) m_armed = 1'b0;
      else if (btn[3] && btn[4]) m_armed = 1'b0;
      else if (e[3] || e[4]) begin
         m_armed = 1'b1;
         m_dir   = e[4];
         m_press = cyc;
         fire    = 1'b1;
      end else if (m_armed && btn[m_dir ? 4 : 3]) begin
         d = cyc - m_press;
         if (d >= int'(H) && ((d - int'(H)) % int'(R)) == 0) fire = 1'b1;
      end else m_armed = 1'b0;
      m_pulse = fire ? (6'b000001 << ((nf - 1) * 2 + int'(m_dir))) : 6'b000000;
      if (nf == 0) m_blink = 1'b0;
      else begin
         if (nf != m_field) m_t0 = cyc;
         m_blink = (((cyc - m_t0) / int'(B)) % 2) == 0;
      end
      m_field = nf;
   endtask

   task automatic tick();
      @(posedge clk);
      if (!rst) model_reset();
      else model_step();
      @(negedge clk);
      check("model_outputs", {54'd0, o_blink, o_set_mode, o_field, pulses},
            {54'd0, m_blink, (m_field != 0), 2'(m_field), m_pulse});
      check("pulse_onehot", 64'($countones(pulses) <= 1), 64'd1);
   endtask

   function automatic vec_t mk(logic [4:0] b, logic [1:0] f, logic s, logic [5:0] p);
      vec_t v;
      v.btn = b; v.field = f; v.set_mode = s; v.pulse = p;
      return v;
   endfunction

   initial begin
      vec_t        tbl[$];
      logic [63:0] mask;
      int          npulse;

      tbl.push_back(mk(5'b01000, 2'd0, 1'b0, 6'b000000));
      tbl.push_back(mk(5'b00000, 2'd0, 1'b0, 6'b000000));
      tbl.push_back(mk(5'b00010, 2'd0, 1'b0, 6'b000000));
      tbl.push_back(mk(5'b00000, 2'd0, 1'b0, 6'b000000));
      tbl.push_back(mk(5'b00001, 2'd1, 1'b1, 6'b000000));
      tbl.push_back(mk(5'b00000, 2'd1, 1'b1, 6'b000000));
      tbl.push_back(mk(5'b00010, 2'd2, 1'b1, 6'b000000));
      tbl.push_back(mk(5'b00000, 2'd2, 1'b1, 6'b000000));
      tbl.push_back(mk(5'b00010, 2'd3, 1'b1, 6'b000000));
      tbl.push_back(mk(5'b00000, 2'd3, 1'b1, 6'b000000));
      tbl.push_back(mk(5'b00010, 2'd1, 1'b1, 6'b000000));
      tbl.push_back(mk(5'b00000, 2'd1, 1'b1, 6'b000000));
      tbl.push_back(mk(5'b00100, 2'd3, 1'b1, 6'b000000));
      tbl.push_back(mk(5'b00000, 2'd3, 1'b1, 6'b000000));
      tbl.push_back(mk(5'b00100, 2'd2, 1'b1, 6'b000000));
      tbl.push_back(mk(5'b00000, 2'd2, 1'b1, 6'b000000));
      tbl.push_back(mk(5'b01000, 2'd2, 1'b1, 6'b000100));
      tbl.push_back(mk(5'b01000, 2'd2, 1'b1, 6'b000000));
      tbl.push_back(mk(5'b01000, 2'd2, 1'b1, 6'b000000));
      tbl.push_back(mk(5'b00000, 2'd2, 1'b1, 6'b000000));
      tbl.push_back(mk(5'b00010, 2'd3, 1'b1, 6'b000000));
      tbl.push_back(mk(5'b00000, 2'd3, 1'b1, 6'b000000));
      tbl.push_back(mk(5'b10000, 2'd3, 1'b1, 6'b100000));
      tbl.push_back(mk(5'b10000, 2'd3, 1'b1, 6'b000000));
      tbl.push_back(mk(5'b00000, 2'd3, 1'b1, 6'b000000));
      tbl.push_back(mk(5'b11000, 2'd3, 1'b1, 6'b000000));
      tbl.push_back(mk(5'b11000, 2'd3, 1'b1, 6'b000000));
      tbl.push_back(mk(5'b01000, 2'd3, 1'b1, 6'b000000));
      tbl.push_back(mk(5'b01000, 2'd3, 1'b1, 6'b000000));
      tbl.push_back(mk(5'b00000, 2'd3, 1'b1, 6'b000000));
      tbl.push_back(mk(5'b00110, 2'd3, 1'b1, 6'b000000));
      tbl.push_back(mk(5'b00000, 2'd3, 1'b1, 6'b000000));
      tbl.push_back(mk(5'b01001, 2'd0, 1'b0, 6'b000000));
      tbl.push_back(mk(5'b00000, 2'd0, 1'b0, 6'b000000));

      cyc = 0;
      rst = 1'b0;
      btn = '0;
      model_reset();
      repeat (3) tick();
      check("reset_outputs", {58'd0, o_blink, o_set_mode, o_field, o_sec_up | o_hour_down},
            64'd0);
      rst = 1'b1;

      foreach (tbl[i]) begin
         btn = tbl[i].btn;
         tick();
         check($sformatf("vec%0d", i), {55'd0, o_set_mode, o_field, pulses},
               {55'd0, tbl[i].set_mode, tbl[i].field, tbl[i].pulse});
      end

      // Mode held across reset release is not an edge
      btn = 5'b00001;
      rst = 1'b0;
      tick();
      rst = 1'b1;
      repeat (3) tick();
      check("held_through_reset_field", 64'(o_field), 64'd0);
      btn = '0;
      tick();

      // Auto-repeat in SET_SEC
      btn = 5'b00001; tick();
      btn = 5'b00000; tick();
      mask = '0;
      for (int i = 0; i < 36; i++) begin
         btn = (i < 30) ? 5'b01000 : 5'b00000;
         tick();
         if (o_sec_up) mask[i+1] = 1'b1;
      end
      check("repeat_pulse_cycles", mask,
            (64'd1 << 1) | (64'd1 << 11) | (64'd1 << 15) | (64'd1 << 19) | (64'd1 << 23) | (64'd1 << 27));

      // Cursor move during a hold stops repeat until re-press
      btn = 5'b01000; tick();
      repeat (3) tick();
      btn = 5'b01010; tick();
      check("left_during_hold_field", 64'(o_field), 64'd2);
      btn = 5'b01000;
      npulse = 0;
      repeat (20) begin tick(); npulse += $countones(pulses); end
      check("no_repeat_after_move", 64'(npulse), 64'd0);
      btn = 5'b00000; tick();
      btn = 5'b01000; tick();
      check("repress_min_up", 64'(o_min_up), 64'd1);
      btn = 5'b00000; tick();

      // Blink cadence on entering SET and restart on field change
      btn = 5'b00001; tick();
      btn = 5'b00000; tick();
      btn = 5'b00001; tick();
      mask = '0;
      mask[0] = o_blink;
      btn = 5'b00000;
      for (int i = 1; i < 16; i++) begin
         tick();
         mask[i] = o_blink;
      end
      check("blink_pattern", mask, 64'h00FF);
      btn = 5'b00010; tick();
      check("blink_restart_on_left", 64'(o_blink), 64'd1);
      btn = 5'b00000; tick();

      // Reset asserted during repeat
      btn = 5'b01000;
      repeat (15) tick();
      rst = 1'b0;
      #1;
      check("async_reset_outputs", {54'd0, o_blink, o_set_mode, o_field, pulses}, 64'd0);
      @(negedge clk);
      tick();
      rst = 1'b1;
      npulse = 0;
      repeat (5) begin tick(); npulse += $countones(pulses); end
      check("no_pulse_after_reset", 64'(npulse), 64'd0);
      check("run_after_reset", 64'(o_field), 64'd0);
      btn = '0;
      tick();

      // Random button activity
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 39) == 0) btn[0] = ~btn[0];
         if ($urandom_range(0, 15) == 0) btn[1] = ~btn[1];
         if ($urandom_range(0, 15) == 0) btn[2] = ~btn[2];
         if ($urandom_range(0, 24) == 0) btn[3] = ~btn[3];
         if ($urandom_range(0, 24) == 0) btn[4] = ~btn[4];
         rst = ($urandom_range(0, 599) == 0) ? 1'b0 : 1'b1;
         tick();
      end
      rst = 1'b1;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
